led_pattern_loader: RTL and testbench
=====================================

LED_PATTERN_LOADER -- requirements
Module: led_pattern_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, pattern memory address width (4096 entries).
REQ-002 SHALL have parameter DATA_W, default 4, pattern word width (one LED nibble).
REQ-003 SHALL have port gclk  input  1  the only clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  one-cycle load request; sampled only in IDLE.
REQ-006 SHALL have port base_addr  input  ADDR_W  first write address, captured on accepted start.
REQ-007 SHALL have port length  input  ADDR_W+1  nibble count 1..4096, captured on accepted start.
REQ-008 SHALL have port in_valid  input  1  byte-stream valid.
REQ-009 SHALL have port in_data  input  8  byte-stream data: low nibble first, then high nibble.
REQ-010 SHALL have port in_ready  output  1  byte-stream ready; a byte transfers when in_valid and in_ready are both high.
REQ-011 SHALL have port wr_en  output  1  pattern memory write strobe.
REQ-012 SHALL have port wr_addr  output  ADDR_W  pattern memory write address.
REQ-013 SHALL have port wr_data  output  DATA_W  pattern memory write data.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port done  output  1  one-cycle completion pulse.
REQ-016 SHALL have port error  output  1  result of the last load; held until the next accepted start.

Function
REQ-017 SHALL implement states IDLE, RECV, WR_LO, WR_HI, CHECK and DONE.
REQ-018 IDLE: in_ready=0; start=1 with length in 1..4096 -> capture base_addr/length, clear checksum and error, go to RECV.
REQ-019 IDLE: start=1 with length=0 or length>4096 -> no writes, error=1, go to DONE.
REQ-020 RECV: in_ready=1; on transfer, register the byte, XOR it into an 8-bit checksum, and go to WR_LO.
REQ-021 WR_LO: in_ready=0; wr_en=1, wr_addr=current address, wr_data=byte[3:0]; increment address and decrement remaining count.
REQ-022 WR_LO exit: remaining=0 -> CHECK; else -> WR_HI.
REQ-023 WR_HI: in_ready=0; wr_en=1, wr_data=byte[7:4]; same address/count update as WR_LO.
REQ-024 WR_HI exit: remaining=0 -> CHECK; else -> RECV.
REQ-025 Odd length: the high nibble of the final data byte SHALL be discarded and not written; that byte still counts in the checksum.
REQ-026 Write latency: the first wr_en SHALL occur exactly 1 cycle after the byte transfer; throughput is one byte per 3 cycles.
REQ-027 Address SHALL wrap modulo 2^ADDR_W (4095 -> 0) with no error.
REQ-028 CHECK: in_ready=1; the next transferred byte is the checksum; error = (byte != XOR of data bytes); go to DONE.
REQ-029 DONE: done=1 for one cycle, in_ready=0; then go to IDLE.
REQ-030 start outside IDLE SHALL be ignored; in_valid outside RECV/CHECK SHALL be ignored.
REQ-031 wr_en SHALL be 0 in all states except WR_LO and WR_HI.
REQ-032 All outputs SHALL be registered or decoded from state only, with no combinational path from in_valid to in_ready.

Reset
REQ-033 rst=1 SHALL force IDLE and set in_ready, wr_en, busy, done and error to 0; wr_addr and wr_data to 0; checksum and counters to 0.
REQ-034 rst asserted mid-load SHALL abort on the next edge with no further writes; already-written words are not undone.

Structure
REQ-035 ADDR_W, DATA_W and the state encoding SHALL live in a shared package, led_pkg.
REQ-036 The block SHALL be flat (no sub-module), with checksum accumulator, address counter and remaining counter inline.

Verification
REQ-037 base=0x010, len=4, bytes 0x21, 0x43, checksum 0x62 -> writes (0x010,1),(0x011,2),(0x012,3),(0x013,4), done=1, error=0.
REQ-038 base=0xFFE, len=3, bytes 0xA5, 0x0C, checksum 0xA9 -> writes (0xFFE,5),(0xFFF,A),(0x000,C), no 4th write, error=0.
REQ-039 len=2, byte 0x33, checksum 0x00 -> 2 writes, done pulse with error=1.
REQ-040 len=0 start -> no wr_en, done 1 cycle later, error=1; start pulsed while busy -> no effect.
REQ-041 rst after 2nd write of len=8 load -> next cycle busy=0, wr_en=0, in_ready=0; new start proceeds normally.
REQ-042 in_valid held high continuously -> in_ready pattern 1,0,0 repeating; each byte accepted exactly once.

Source files
------------

// File: rtl/led_pkg.sv
// Shared constants and state encoding for the LED pattern loader.
// The loader turns a byte stream into nibble writes to a pattern memory.
package led_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WR_LO = 3'd2,
        WR_HI = 3'd3,
        CHECK = 3'd4,
        DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/led_pattern_loader_if.sv
// Byte-stream input and pattern-memory write port of the LED pattern loader.
interface led_pattern_loader_if #(
    parameter int ADDR_W = led_pkg::ADDR_W,
    parameter int DATA_W = led_pkg::DATA_W
);
    // A byte moves on every rising edge where in_valid and in_ready are both high;
    // in_ready never depends on in_valid, and the source must hold in_data while waiting.
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data
    );

endinterface

// File: rtl/led_pattern_loader.sv
// Loads a checksummed byte stream into pattern memory as consecutive nibbles,
// low nibble first, with address wrap and a trailing XOR checksum check.
module led_pattern_loader #(
    parameter int ADDR_W = led_pkg::ADDR_W,
    parameter int DATA_W = led_pkg::DATA_W
) (
    input  logic                 gclk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [ADDR_W:0]      length,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output led_pkg::state_t      dbg_state,
    led_pattern_loader_if.slave  bus
);
    import led_pkg::*;

    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic [7:0]        byte_q, byte_d;
    logic [7:0]        csum_q, csum_d;
    logic              error_q, error_d;

    always_ff @(posedge gclk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            byte_q  <= '0;
            csum_q  <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            byte_q  <= byte_d;
            csum_q  <= csum_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        byte_d  = byte_q;
        csum_d  = csum_q;
        error_d = error_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (length != '0 && length <= MAX_LEN) begin
                        addr_d  = base_addr;
                        rem_d   = length;
                        csum_d  = '0;
                        error_d = 1'b0;
                        state_d = RECV;
                    end else begin
                        error_d = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            RECV: begin
                if (bus.in_valid) begin
                    byte_d  = bus.in_data;
                    csum_d  = csum_q ^ bus.in_data;
                    state_d = WR_LO;
                end
            end
            WR_LO, WR_HI: begin
                // Odd counts end after WR_LO, so the final high nibble is never written.
                addr_d = addr_q + ADDR_W'(1);
                rem_d  = rem_q - (ADDR_W+1)'(1);
                if (rem_q == (ADDR_W+1)'(1)) begin
                    state_d = CHECK;
                end else if (state_q == WR_LO) begin
                    state_d = WR_HI;
                end else begin
                    state_d = RECV;
                end
            end
            CHECK: begin
                if (bus.in_valid) begin
                    error_d = (bus.in_data != csum_q);
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready = (state_q == RECV) || (state_q == CHECK);
    assign bus.wr_en    = (state_q == WR_LO) || (state_q == WR_HI);
    assign bus.wr_addr  = addr_q;
    assign bus.wr_data  = (state_q == WR_HI) ? DATA_W'(byte_q[7:4]) : DATA_W'(byte_q[3:0]);
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);
    assign error        = error_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_led_pattern_loader.sv
// Directed bench for led_pattern_loader: checks write sequences, checksum
// result, wrap, rejected lengths, mid-load reset and streaming handshake.
module tb_led_pattern_loader;
  import led_pkg::*;

  logic        gclk;
  logic        rst;
  logic        start;
  logic [11:0] base_addr;
  logic [12:0] length;
  logic        busy;
  logic        done;
  logic        error;
  state_t      dbg_state;

  led_pattern_loader_if bus ();

  led_pattern_loader dut (
    .gclk      (gclk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .dbg_state (dbg_state),
    .bus       (bus.slave)
  );

  int n_asserts = 0;
  int n_fail    = 0;

  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];

  // clock / reset
  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  // write monitor: {addr, data} of every strobe, sampled on the falling edge
  always @(negedge gclk) begin
    if (bus.wr_en === 1'b1) obs_q.push_back({bus.wr_addr, bus.wr_data});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [11:0] b, input logic [12:0] l);
    start     = 1'b1;
    base_addr = b;
    length    = l;
    @(negedge gclk);
    start = 1'b0;
  endtask

  task automatic send_byte(input string tag, input logic [7:0] b);
    int cnt = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (bus.in_ready !== 1'b1 && cnt < 50) begin
      @(negedge gclk);
      cnt++;
    end
    chk({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
    @(negedge gclk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input logic exp_err);
    int cnt = 0;
    while (done !== 1'b1 && cnt < 50) begin
      @(negedge gclk);
      cnt++;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_error"}, 32'(error), 32'(exp_err));
    @(negedge gclk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_wr_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk($sformatf("%s_wr%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    base_addr    = '0;
    length       = '0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(negedge gclk);

    // reset state
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_wr_en",    32'(bus.wr_en),    32'd0);
    chk("rst_busy",     32'(busy),         32'd0);
    chk("rst_done",     32'(done),         32'd0);
    chk("rst_error",    32'(error),        32'd0);
    chk("rst_wr_addr",  32'(bus.wr_addr),  32'd0);
    chk("rst_wr_data",  32'(bus.wr_data),  32'd0);
    chk("rst_state",    32'(dbg_state),    32'(IDLE));
    rst = 1'b0;
    @(negedge gclk);

    // even length, four nibbles
    obs_q.delete();
    exp_q = {16'h0101, 16'h0112, 16'h0123, 16'h0134};
    do_start(12'h010, 13'd4);
    chk("t1_busy", 32'(busy), 32'd1);
    send_byte("t1_b0", 8'h21);
    chk("t1_lat_wr_en",   32'(bus.wr_en),   32'd1);
    chk("t1_lat_wr_addr", 32'(bus.wr_addr), 32'h010);
    chk("t1_lat_wr_data", 32'(bus.wr_data), 32'h1);
    send_byte("t1_b1", 8'h43);
    send_byte("t1_cs", 8'h62);
    wait_done("t1", 1'b0);
    check_writes("t1");

    // odd length with address wrap
    obs_q.delete();
    exp_q = {16'hFFE5, 16'hFFFA, 16'h000C};
    do_start(12'hFFE, 13'd3);
    send_byte("t2_b0", 8'hA5);
    send_byte("t2_b1", 8'h0C);
    send_byte("t2_cs", 8'hA9);
    wait_done("t2", 1'b0);
    check_writes("t2");

    // bad checksum
    obs_q.delete();
    exp_q = {16'h1003, 16'h1013};
    do_start(12'h100, 13'd2);
    send_byte("t3_b0", 8'h33);
    send_byte("t3_cs", 8'h00);
    wait_done("t3", 1'b1);
    check_writes("t3");

    // zero length and over-long requests
    obs_q.delete();
    exp_q.delete();
    do_start(12'h123, 13'd0);
    chk("t4_len0_done",  32'(done),      32'd1);
    chk("t4_len0_error", 32'(error),     32'd1);
    chk("t4_len0_busy",  32'(busy),      32'd1);
    chk("t4_len0_wr_en", 32'(bus.wr_en), 32'd0);
    @(negedge gclk);
    chk("t4_len0_done_pulse", 32'(done),  32'd0);
    chk("t4_len0_idle",       32'(busy),  32'd0);
    chk("t4_len0_err_held",   32'(error), 32'd1);
    do_start(12'h000, 13'd4097);
    chk("t4_len4097_done",  32'(done),  32'd1);
    chk("t4_len4097_error", 32'(error), 32'd1);
    @(negedge gclk);
    check_writes("t4");

    // start pulsed while busy is ignored
    obs_q.delete();
    exp_q = {16'h200A, 16'h2015};
    do_start(12'h200, 13'd2);
    chk("t5_err_cleared", 32'(error), 32'd0);
    send_byte("t5_b0", 8'h5A);
    do_start(12'h300, 13'd1);
    send_byte("t5_cs", 8'h5A);
    wait_done("t5", 1'b0);
    check_writes("t5");

    // reset after the second write of an eight-nibble load
    obs_q.delete();
    exp_q = {16'h0206, 16'h0217};
    do_start(12'h020, 13'd8);
    send_byte("t6_b0", 8'h76);
    @(negedge gclk);
    rst = 1'b1;
    @(negedge gclk);
    chk("t6_rst_busy",     32'(busy),         32'd0);
    chk("t6_rst_wr_en",    32'(bus.wr_en),    32'd0);
    chk("t6_rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("t6_rst_wr_addr",  32'(bus.wr_addr),  32'd0);
    rst = 1'b0;
    @(negedge gclk);
    check_writes("t6");
    obs_q.delete();
    exp_q = {16'h0308, 16'h0319};
    do_start(12'h030, 13'd2);
    send_byte("t6b_b0", 8'h98);
    send_byte("t6b_cs", 8'h98);
    wait_done("t6b", 1'b0);
    check_writes("t6b");

    // in_valid held high: ready pattern 1,0,0 and one acceptance per byte
    obs_q.delete();
    exp_q = {16'h0401, 16'h0411, 16'h0422, 16'h0432};
    do_start(12'h040, 13'd4);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h11;
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("t7_ready_k%0d", k), 32'(bus.in_ready), 32'((k % 3) == 0));
      if (k == 1) bus.in_data = 8'h22;
      if (k == 4) bus.in_data = 8'h33;
      @(negedge gclk);
    end
    chk("t7_done",      32'(done),         32'd1);
    chk("t7_done_rdy",  32'(bus.in_ready), 32'd0);
    chk("t7_error",     32'(error),        32'd0);
    @(negedge gclk);
    bus.in_valid = 1'b0;
    chk("t7_idle", 32'(busy), 32'd0);
    @(negedge gclk);
    check_writes("t7");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
